// File: rtl/seg_scan_driver.sv
// Time-multiplexed seven-segment scan driver: one nibble and one active-low digit
// enable per slot, with new values committed only at frame boundaries.
module seg_scan_driver #(
    parameter int DIGITS = 8,
    parameter int DIV    = 50000,
    parameter int GHOST  = 500
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_valid,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  blank_lead,
    output logic                  load_ready,
    output logic [3:0]            nibble,
    output logic [DIGITS-1:0]     an_n
);

    localparam int CW = $clog2(DIV);
    localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [DW-1:0] DIG_LAST = DW'(DIGITS - 1);
    localparam logic [CW-1:0] GHOST_C  = CW'(GHOST);

    logic [CW-1:0]         cnt;
    logic [DW-1:0]         dig;
    logic [4*DIGITS-1:0]   active;
    logic [4*DIGITS-1:0]   shadow;
    logic                  pending;
    logic                  blank_q;

    logic                  slot_end;
    logic                  frame_end;
    logic [DW-1:0]         top_nz;
    logic                  blanked;
    logic                  lit;

    assign slot_end   = (cnt == CNT_LAST);
    assign frame_end  = slot_end && (dig == DIG_LAST);
    assign load_ready = !pending;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            dig     <= '0;
            active  <= '0;
            shadow  <= '0;
            pending <= 1'b0;
            blank_q <= 1'b0;
        end else begin
            // blank_lead is registered so the outputs depend on state only
            blank_q <= blank_lead;
            if (slot_end) begin
                cnt <= '0;
                dig <= (dig == DIG_LAST) ? '0 : dig + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
            // A load accepted on the boundary edge waits for the next boundary
            if (frame_end && pending) begin
                active  <= shadow;
                pending <= 1'b0;
            end else if (load_valid && !pending) begin
                shadow  <= value;
                pending <= 1'b1;
            end
        end
    end

    always_comb begin
        top_nz = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (active[4*k +: 4] != 4'd0) top_nz = DW'(k);
        end
    end

    // Digit 0 can never exceed top_nz, so it is never blanked
    assign blanked = blank_q && (dig > top_nz);
    assign lit     = !blanked && (cnt >= GHOST_C);
    assign nibble  = active[4*dig +: 4];

    always_comb begin
        an_n = '1;
        if (lit) an_n[dig] = 1'b0;
    end

endmodule
